// File: rtl/mio_bus_master_pkg.sv
// rtl/mio_bus_master_pkg.sv - shared encodings and request legality check for the MIO bus sequencer
package mio_bus_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // word_ok is low on buses narrower than a 32-bit word
    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo,
                                        input logic word_ok);
        case (size)
            SZ_BYTE: access_bad = 1'b0;
            SZ_HALF: access_bad = addr_lo[0];
            SZ_WORD: access_bad = (addr_lo != 2'b00) || !word_ok;
            default: access_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mio_bus_master_if.sv
// rtl/mio_bus_master_if.sv - core request/response and MIO bus signal bundle
interface mio_bus_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic [1:0]            rsp_err;
    logic [ADDR_W-1:0]     Addr_out;
    logic [DATA_W-1:0]     Data_out;
    logic [DATA_W/8-1:0]   byte_en;
    logic                  mem_w;
    logic                  CPU_MIO;
    logic                  MIO_ready;
    logic [DATA_W-1:0]     Data_in;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, MIO_ready, Data_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, Addr_out, Data_out, byte_en, mem_w, CPU_MIO
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, MIO_ready, Data_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, Addr_out, Data_out, byte_en, mem_w, CPU_MIO
    );
endinterface

// File: rtl/mio_lane_align.sv
// rtl/mio_lane_align.sv - byte-lane enables, store replication and load extract/extend (combinational)
module mio_lane_align
    import mio_bus_master_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                  size,
    input  logic                        sgn,
    input  logic [$clog2(DATA_W/8)-1:0] lane,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W-1:0]           bus_rdata,
    output logic [DATA_W/8-1:0]         byte_en,
    output logic [DATA_W-1:0]           wdata_rep,
    output logic [DATA_W-1:0]           rdata_ext
);
    localparam int NB = DATA_W / 8;
    localparam int WW = (DATA_W < 32) ? DATA_W : 32;

    logic [DATA_W-1:0] shifted;
    logic [NB-1:0]     be_mask;

    always_comb begin
        shifted   = bus_rdata >> {lane, 3'b000};
        be_mask   = '0;
        wdata_rep = '0;
        rdata_ext = '0;
        case (size)
            SZ_BYTE: begin
                be_mask = NB'(1);
                for (int k = 0; k < NB; k++) wdata_rep[8*k +: 8] = wdata[7:0];
                rdata_ext = sgn ? DATA_W'($signed(shifted[7:0])) : DATA_W'(shifted[7:0]);
            end
            SZ_HALF: begin
                be_mask = NB'(3);
                for (int k = 0; k < NB/2; k++) wdata_rep[16*k +: 16] = wdata[15:0];
                rdata_ext = sgn ? DATA_W'($signed(shifted[15:0])) : DATA_W'(shifted[15:0]);
            end
            default: begin
                be_mask = NB'(15);
                for (int k = 0; k < DATA_W/WW; k++) wdata_rep[WW*k +: WW] = wdata[WW-1:0];
                rdata_ext = sgn ? DATA_W'($signed(shifted[WW-1:0])) : DATA_W'(shifted[WW-1:0]);
            end
        endcase
        byte_en = be_mask << lane;
    end

endmodule

// File: rtl/mio_bus_master.sv
// rtl/mio_bus_master.sv - request sequencer onto the MIO bus with INT sync; MIO_TIMEOUT_EN adds a BUS-wait timeout
module mio_bus_master
    import mio_bus_master_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             reset,
    mio_bus_master_if.master bus,
    input  logic             INT,
    input  logic             int_ack,
    output logic             int_pending,
    output logic [1:0]       state
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;
    logic              int_s1_q, int_s2_q, int_s3_q;
    logic              int_pending_q, int_pending_d;
    logic              req_bad, in_bus, in_resp, timeout;
    logic [NB-1:0]     lane_be;
    logic [DATA_W-1:0] lane_wdata, lane_rdata;

`ifdef MIO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

    assign req_bad = access_bad(bus.req_size, bus.req_addr[1:0], DATA_W >= 32);

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        sgn_d         = sgn_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
`ifdef MIO_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        int_pending_d = (int_s2_q & ~int_s3_q) | (int_pending_q & ~int_ack);
        case (state_q)
            ST_IDLE: if (bus.req_valid) begin
                we_d    = bus.req_we;
                size_d  = bus.req_size;
                sgn_d   = bus.req_signed;
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                rdata_d = '0;
                err_d   = req_bad ? ERR_ALIGN : ERR_OK;
                state_d = req_bad ? ST_RESP : ST_BUS;
`ifdef MIO_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            // MIO_ready wins over a timeout landing in the same cycle
            ST_BUS: if (bus.MIO_ready) begin
                rdata_d = bus.Data_in;
                state_d = ST_RESP;
            end else if (timeout) begin
                err_d   = ERR_TIMEOUT;
                state_d = ST_RESP;
            end else begin
`ifdef MIO_TIMEOUT_EN
                cnt_d   = cnt_q + 1'b1;
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            we_q          <= 1'b0;
            size_q        <= SZ_BYTE;
            sgn_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            err_q         <= ERR_OK;
            int_s1_q      <= 1'b0;
            int_s2_q      <= 1'b0;
            int_s3_q      <= 1'b0;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            sgn_q         <= sgn_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            int_s1_q      <= INT;
            int_s2_q      <= int_s1_q;
            int_s3_q      <= int_s2_q;
            int_pending_q <= int_pending_d;
        end
    end

`ifdef MIO_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    mio_lane_align #(.DATA_W(DATA_W)) u_lane (
        .size      (size_q),
        .sgn       (sgn_q),
        .lane      (addr_q[LB-1:0]),
        .wdata     (wdata_q),
        .bus_rdata (rdata_q),
        .byte_en   (lane_be),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // Bus outputs decode straight from state so an async reset drops them without a clock
    assign in_bus        = (state_q == ST_BUS);
    assign in_resp       = (state_q == ST_RESP);
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = in_resp;
    assign bus.rsp_err   = in_resp ? err_q : ERR_OK;
    assign bus.rsp_rdata = (in_resp && err_q == ERR_OK && !we_q) ? lane_rdata : '0;
    assign bus.CPU_MIO   = in_bus;
    assign bus.mem_w     = in_bus & we_q;
    assign bus.Addr_out  = in_bus ? {addr_q[ADDR_W-1:LB], {LB{1'b0}}} : '0;
    assign bus.Data_out  = in_bus ? lane_wdata : '0;
    assign bus.byte_en   = in_bus ? lane_be : '0;
    assign int_pending   = int_pending_q;
    assign state         = state_q;

endmodule

// File: tb/tb_mio_bus_master.sv
// tb/tb_mio_bus_master.sv - directed scoreboard bench for mio_bus_master
module tb_mio_bus_master;
    import mio_bus_master_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       INT;
    logic       int_ack;
    logic       int_pending;
    logic [1:0] state;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mio_bus_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mio_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .INT         (INT),
        .int_ack     (int_ack),
        .int_pending (int_pending),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] a, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*a[1:0] +: 8];
        h = d[16*a[1] +: 16];
        case (sz)
            2'd0:    m_load = sg ? {{24{b[7]}}, b} : {24'h0, b};
            2'd1:    m_load = sg ? {{16{h[15]}}, h} : {16'h0, h};
            default: m_load = d;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] one;
        logic [3:0] two;
        one = 4'b0001;
        two = 4'b0011;
        case (sz)
            2'd0:    m_be = one << a[1:0];
            2'd1:    m_be = two << a[1:0];
            default: m_be = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_dout(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'd0:    m_dout = {4{wd[7:0]}};
            2'd1:    m_dout = {2{wd[15:0]}};
            default: m_dout = wd;
        endcase
    endfunction

    task automatic check_bus(input string tag, input logic we, input logic [1:0] sz,
                             input logic [31:0] addr, input logic [31:0] wd);
        chk({tag, "/cpu_mio"},  bus.CPU_MIO, 1);
        chk({tag, "/state"},    state, 1);
        chk({tag, "/mem_w"},    bus.mem_w, we);
        chk({tag, "/addr_out"}, bus.Addr_out, {addr[31:2], 2'b00});
        chk({tag, "/byte_en"},  bus.byte_en, m_be(sz, addr));
        if (we) chk({tag, "/data_out"}, bus.Data_out, m_dout(sz, wd));
    endtask

    task automatic drive_req(input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
    endtask

    task automatic take_rsp(input string tag);
        exp_t e;
        chk({tag, "/rsp_valid"}, bus.rsp_valid, 1);
        chk({tag, "/rsp_cpu_mio"}, bus.CPU_MIO, 0);
        if (bus.rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "/rsp_rdata"}, bus.rsp_rdata, e.rdata);
            chk({tag, "/rsp_err"},   bus.rsp_err, e.err);
        end
        @(negedge clk);
        chk({tag, "/rsp_one_cycle"}, bus.rsp_valid, 0);
        chk({tag, "/back_idle"}, state, 0);
    endtask

    task automatic run_req(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int wait_cyc, input logic [31:0] din);
        exp_t e;
        logic acc_bad;
        acc_bad = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
        e.err   = acc_bad ? 2'd1 : 2'd0;
        e.rdata = (acc_bad || we) ? 32'h0 : m_load(sz, sg, addr, din);
        sb.push_back(e);
        @(negedge clk);
        chk({tag, "/req_ready"}, bus.req_ready, 1);
        drive_req(we, sz, sg, addr, wd);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (!acc_bad) begin
            for (int i = 0; i <= wait_cyc; i++) begin
                check_bus(tag, we, sz, addr, wd);
                if (i == wait_cyc) begin
                    bus.MIO_ready = 1'b1;
                    bus.Data_in   = din;
                end
                @(negedge clk);
            end
            bus.MIO_ready = 1'b0;
            bus.Data_in   = $urandom;
        end
        take_rsp(tag);
    endtask

    initial begin
        int         n;
        logic [1:0] rsz;
        logic [31:0] ra;
        exp_t       e;

        reset          = 1'b0;
        INT            = 1'b0;
        int_ack        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.MIO_ready  = 1'b0;
        bus.Data_in    = '0;
        repeat (2) @(negedge clk);
        chk("reset/state",       state, 0);
        chk("reset/req_ready",   bus.req_ready, 1);
        chk("reset/rsp_valid",   bus.rsp_valid, 0);
        chk("reset/rsp_rdata",   bus.rsp_rdata, 0);
        chk("reset/rsp_err",     bus.rsp_err, 0);
        chk("reset/addr_out",    bus.Addr_out, 0);
        chk("reset/data_out",    bus.Data_out, 0);
        chk("reset/byte_en",     bus.byte_en, 0);
        chk("reset/mem_w",       bus.mem_w, 0);
        chk("reset/cpu_mio",     bus.CPU_MIO, 0);
        chk("reset/int_pending", int_pending, 0);
        reset = 1'b1;

        run_req("word_load",   1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        run_req("sbyte_load",  1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80112233);
        run_req("ubyte_load",  1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1, 32'h80112233);
        run_req("shalf_load",  1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 2, 32'h9ABC5678);
        run_req("half_store",  1'b1, 2'd1, 1'b0, 32'h202, 32'h1234, 3, 32'hFFFFFFFF);
        run_req("byte_store",  1'b1, 2'd0, 1'b0, 32'h201, 32'hA5, 1, 32'h0);
        run_req("misal_word",  1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'h12345678);
        run_req("misal_half",  1'b1, 2'd1, 1'b0, 32'h105, 32'hBEEF, 0, 32'h0);
        run_req("size3",       1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 32'h12345678);

        for (int k = 0; k < 8; k++) begin
            rsz = 2'($urandom_range(0, 2));
            ra  = $urandom & 32'hFFFF_FFFC;
            ra  = ra | (rsz == 2'd0 ? 32'($urandom_range(0, 3)) :
                        rsz == 2'd1 ? 32'($urandom_range(0, 1) * 2) : 32'h0);
            run_req("rand", 1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra,
                    $urandom, $urandom_range(0, 3), $urandom);
        end

        @(negedge clk);
        bus.MIO_ready = 1'b1;
        @(negedge clk);
        bus.MIO_ready = 1'b0;
        chk("stray_ready/state", state, 0);
        chk("stray_ready/rsp_valid", bus.rsp_valid, 0);

`ifdef MIO_TIMEOUT_EN
        e.rdata = 32'h0;
        e.err   = 2'd2;
        sb.push_back(e);
        @(negedge clk);
        drive_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.CPU_MIO && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("timeout/cpu_mio_cycles", n, 4);
        take_rsp("timeout");
`else
        run_req("long_wait", 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 110, 32'h0BADF00D);
`endif

        @(negedge clk);
        drive_req(1'b1, 2'd2, 1'b0, 32'h300, 32'h55AA55AA);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid/cpu_mio_before", bus.CPU_MIO, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid/cpu_mio_async", bus.CPU_MIO, 0);
        chk("rst_mid/mem_w_async", bus.mem_w, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid/no_rsp", bus.rsp_valid, 0);
            chk("rst_mid/state", state, 0);
            chk("rst_mid/req_ready", bus.req_ready, 1);
        end

        @(negedge clk);
        INT = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        n = 0;
        while (!int_pending && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("int/set", int_pending, 1);
        chk("int/within_3", n <= 2, 1);
        repeat (3) @(negedge clk);
        chk("int/sticky", int_pending, 1);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        chk("int/ack_clears", int_pending, 0);

        INT = 1'b1;
        repeat (2) @(negedge clk);
        INT = 1'b0;
        repeat (4) @(negedge clk);
        chk("int/reset_up", int_pending, 1);
        INT = 1'b1;
        repeat (2) @(negedge clk);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        chk("int/edge_beats_ack", int_pending, 1);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        chk("int/ack_after_edge", int_pending, 0);

        chk("sb/empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
